imem_boot_ctrl: RTL and testbench

- Boot/load controller for the byte-addressed instruction memory.
- Accepts 32-bit program words on a valid/ready stream and serialises each word into four byte writes. Byte order is big-endian: byte at addr is the MSB, which matches the fetch-side concatenation.
- Holds the core in stall with PC reset while loading.
- Muxes the memory address between loader and fetch, and hands the memory to fetch when the load finishes.

---
 rtl/imem_boot_ctrl.sv | 158 +++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: serialises 32-bit program words into big-endian byte
// writes to instruction memory, stalls the core while loading, then hands the memory to fetch.
module imem_boot_ctrl #(
  parameter int BUS_WIDTH     = 32,
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 1024,
  parameter int BOOT_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 boot_req,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [BUS_WIDTH-1:0] ld_data,
  input  logic                 ld_last,
  input  logic [BUS_WIDTH-1:0] fetch_addr,
  output logic [BUS_WIDTH-1:0] imem_addr,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_stall,
  output logic                 pc_rst,
  output logic                 boot_done,
  output logic                 ld_err,
  output logic [BUS_WIDTH-1:0] word_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [BUS_WIDTH:0] depth_c = (BUS_WIDTH+1)'(DEPTH);

  state_t                 state_r, state_s;
  logic [1:0]             bcnt_r;
  logic [BUS_WIDTH-1:0]   wbuf_r;
  logic [BUS_WIDTH-1:0]   base_r;
  logic [BUS_WIDTH-1:0]   word_cnt_r;
  logic                   last_r;
  logic                   skip_r;
  logic                   ld_err_r;
  logic                   boot_done_r;
  logic                   ovf_s;
  logic [WIDTH-1:0]       byte_s;

  // Computed one bit wider so a base near the top of the address space cannot wrap past the guard.
  assign ovf_s = ({1'b0, base_r} + {{(BUS_WIDTH-2){1'b0}}, 3'd4}) > depth_c;

  assign word_cnt  = word_cnt_r;
  assign ld_err    = ld_err_r;
  assign boot_done = boot_done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= (BOOT_ON_RESET != 32'sd0) ? ST_WAIT : ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and memory/core control outputs.
  always_comb begin
    state_s   = state_r;
    ld_ready  = 1'b0;
    cpu_stall = 1'b1;
    pc_rst    = 1'b1;
    mem_we    = 1'b0;
    mem_wdata = {WIDTH{1'b0}};
    imem_addr = base_r + {{(BUS_WIDTH-2){1'b0}}, bcnt_r};
    // Byte 0 of a word is its MSB so memory order matches the fetch-side concatenation.
    case (bcnt_r)
      2'd0:    byte_s = wbuf_r[BUS_WIDTH-1 -: WIDTH];
      2'd1:    byte_s = wbuf_r[BUS_WIDTH-1-WIDTH -: WIDTH];
      2'd2:    byte_s = wbuf_r[BUS_WIDTH-1-2*WIDTH -: WIDTH];
      default: byte_s = wbuf_r[BUS_WIDTH-1-3*WIDTH -: WIDTH];
    endcase
    case (state_r)
      ST_WAIT: begin
        ld_ready = 1'b1;
        if (ld_valid) state_s = ST_WRITE;
        else          state_s = ST_WAIT;
      end
      ST_WRITE: begin
        mem_we = ~skip_r;
        if (!skip_r) mem_wdata = byte_s;
        else         mem_wdata = {WIDTH{1'b0}};
        if (bcnt_r == 2'd3) begin
          if (last_r) state_s = ST_DONE;
          else        state_s = ST_WAIT;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        pc_rst    = 1'b0;
        imem_addr = fetch_addr;
        if (boot_req) state_s = ST_WAIT;
        else          state_s = ST_RUN;
      end
      default: begin
        state_s = ST_WAIT;
      end
    endcase
  end

  // Load datapath: word latch, byte counter, base address, counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_r      <= 2'd0;
      wbuf_r      <= {BUS_WIDTH{1'b0}};
      base_r      <= {BUS_WIDTH{1'b0}};
      word_cnt_r  <= {BUS_WIDTH{1'b0}};
      last_r      <= 1'b0;
      skip_r      <= 1'b0;
      ld_err_r    <= 1'b0;
      boot_done_r <= 1'b0;
    end else begin
      boot_done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_WAIT: begin
          if (ld_valid) begin
            wbuf_r <= ld_data;
            last_r <= ld_last;
            skip_r <= ovf_s;
            bcnt_r <= 2'd0;
            if (ovf_s) ld_err_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          bcnt_r <= bcnt_r + 2'd1;
          // A dropped (overflowing) word leaves base and word_cnt untouched.
          if ((bcnt_r == 2'd3) && !skip_r) begin
            base_r     <= base_r + {{(BUS_WIDTH-3){1'b0}}, 3'd4};
            word_cnt_r <= word_cnt_r + {{(BUS_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (boot_req) begin
            base_r     <= {BUS_WIDTH{1'b0}};
            word_cnt_r <= {BUS_WIDTH{1'b0}};
            ld_err_r   <= 1'b0;
            bcnt_r     <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: a default-depth instance and an 8-byte
// instance run in lockstep on the same stimulus; expected byte writes are queued per instance.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot_req = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_last = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic [31:0] fetch_addr = 32'h0;

  logic        ld_ready, mem_we, cpu_stall, pc_rst, boot_done, ld_err;
  logic [31:0] imem_addr, word_cnt;
  logic [7:0]  mem_wdata;
  logic        ld_ready8, mem_we8, cpu_stall8, pc_rst8, boot_done8, ld_err8;
  logic [31:0] imem_addr8, word_cnt8;
  logic [7:0]  mem_wdata8;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_now = 0;
  int          acc_prev = 0;
  logic [39:0] q[$];
  logic [39:0] q8[$];
  logic [31:0] exp_base = 32'h0;
  logic [31:0] exp_base8 = 32'h0;

  imem_boot_ctrl #(.BUS_WIDTH(32), .WIDTH(8), .DEPTH(1024), .BOOT_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .boot_req(boot_req), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .fetch_addr(fetch_addr), .imem_addr(imem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .pc_rst(pc_rst),
    .boot_done(boot_done), .ld_err(ld_err), .word_cnt(word_cnt)
  );

  imem_boot_ctrl #(.BUS_WIDTH(32), .WIDTH(8), .DEPTH(8), .BOOT_ON_RESET(1)) dut8 (
    .clk(clk), .rst(rst), .boot_req(boot_req), .ld_valid(ld_valid), .ld_ready(ld_ready8),
    .ld_data(ld_data), .ld_last(ld_last), .fetch_addr(fetch_addr), .imem_addr(imem_addr8),
    .mem_we(mem_we8), .mem_wdata(mem_wdata8), .cpu_stall(cpu_stall8), .pc_rst(pc_rst8),
    .boot_done(boot_done8), .ld_err(ld_err8), .word_cnt(word_cnt8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One clock: at the falling edge pop/compare any memory write, then land 1 time unit after the rising edge.
  task automatic step();
    logic [39:0] e;
    @(negedge clk);
    if (mem_we === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL unexpected_write: addr=%h data=%h, no write expected", imem_addr, mem_wdata);
      end else begin
        e = q.pop_front();
        if ({imem_addr, mem_wdata} !== e) begin
          errors++; $display("FAIL write: got addr=%h data=%h want addr=%h data=%h", imem_addr, mem_wdata, e[39:8], e[7:0]);
        end
      end
    end else if (mem_we === 1'b0) begin
      checks++;
      if (mem_wdata !== 8'h00) begin
        errors++; $display("FAIL idle_wdata: got %h want 00", mem_wdata);
      end
    end
    if (mem_we8 === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++; $display("FAIL unexpected_write8: addr=%h data=%h, no write expected", imem_addr8, mem_wdata8);
      end else begin
        e = q8.pop_front();
        if ({imem_addr8, mem_wdata8} !== e) begin
          errors++; $display("FAIL write8: got addr=%h data=%h want addr=%h data=%h", imem_addr8, mem_wdata8, e[39:8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    q8.delete();
    exp_base = 32'h0;
    exp_base8 = 32'h0;
  endtask

  // gap==0: present the word at once and hold it; gap>0: wait for ready, then idle gap cycles in WAIT.
  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    int n;
    logic [7:0] bt;
    ld_data = d;
    ld_last = l;
    if (gap == 0) ld_valid = 1'b1;
    n = 0;
    while (ld_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (ld_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: ld_ready=%b want 1 within 40 cycles", ld_ready);
      ld_valid = 1'b0;
      return;
    end
    repeat (gap) step();
    ld_valid = 1'b1;
    acc_prev = acc_now;
    acc_now = cyc;
    for (int b = 0; b < 4; b++) begin
      bt = d[31-8*b -: 8];
      q.push_back({exp_base + 32'(b), bt});
      if (exp_base8 + 32'd4 <= 32'd8) q8.push_back({exp_base8 + 32'(b), bt});
    end
    exp_base = exp_base + 32'd4;
    if (exp_base8 + 32'd4 <= 32'd8) exp_base8 = exp_base8 + 32'd4;
    step();
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_stall !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL run_timeout: cpu_stall=%b want 0 within 60 cycles", cpu_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ld_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b want 1", ld_ready); end
    checks++; if (cpu_stall !== 1'b1)  begin errors++; $display("FAIL reset_stall: got %b want 1", cpu_stall); end
    checks++; if (pc_rst !== 1'b1)     begin errors++; $display("FAIL reset_pc_rst: got %b want 1", pc_rst); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
    checks++; if (word_cnt !== 32'h0)  begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    checks++; if (ld_err !== 1'b0)     begin errors++; $display("FAIL reset_ld_err: got %b want 0", ld_err); end
    checks++; if (boot_done !== 1'b0)  begin errors++; $display("FAIL reset_boot_done: got %b want 0", boot_done); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_word();
    send_word(32'h00500093, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we[%0d]: got %b want 1", i, mem_we); end
      checks++; if (imem_addr !== 32'(i)) begin errors++; $display("FAIL single_addr[%0d]: got %h want %h", i, imem_addr, i); end
      step();
    end
    checks++; if (cpu_stall !== 1'b1 || pc_rst !== 1'b1) begin errors++; $display("FAIL done_stall: stall=%b pc_rst=%b want 1 1", cpu_stall, pc_rst); end
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL done_pulse_early: got %b want 0", boot_done); end
    checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL single_word_cnt: got %0d want 1", word_cnt); end
    step();
    checks++; if (cpu_stall !== 1'b0 || pc_rst !== 1'b0) begin errors++; $display("FAIL run_stall: stall=%b pc_rst=%b want 0 0", cpu_stall, pc_rst); end
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL boot_done_pulse: got %b want 1", boot_done); end
    step();
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL boot_done_width: got %b want 0", boot_done); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL single_pending: got %0d bytes left want 0", q.size()); end
  endtask

  task automatic test_gaps_and_overflow();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    send_word(32'h11223344, 1'b0, 0);
    send_word(32'hA5B6C7D8, 1'b0, 2);
    checks++; if (acc_now - acc_prev != 7) begin errors++; $display("FAIL gap2_spacing: got %0d cycles want 7", acc_now - acc_prev); end
    send_word(32'hDEADBEEF, 1'b1, 0);
    checks++; if (acc_now - acc_prev != 5) begin errors++; $display("FAIL back_to_back_spacing: got %0d cycles want 5", acc_now - acc_prev); end
    wait_run();
    checks++; if (word_cnt !== 32'd3) begin errors++; $display("FAIL gaps_word_cnt: got %0d want 3", word_cnt); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL gaps_ld_err: got %b want 0", ld_err); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL gaps_pending: got %0d bytes left want 0", q.size()); end
    checks++; if (word_cnt8 !== 32'd2) begin errors++; $display("FAIL ovf_word_cnt: got %0d want 2", word_cnt8); end
    checks++; if (ld_err8 !== 1'b1) begin errors++; $display("FAIL ovf_ld_err: got %b want 1", ld_err8); end
    checks++; if (cpu_stall8 !== 1'b0) begin errors++; $display("FAIL ovf_run: stall=%b want 0", cpu_stall8); end
    checks++; if (q8.size() != 0) begin errors++; $display("FAIL ovf_pending: got %0d bytes left want 0", q8.size()); end
  endtask

  task automatic test_run_fetch();
    fetch_addr = 32'h8;
    #1;
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fetch_pass_8: got %h want 8", imem_addr); end
    fetch_addr = 32'h3FC;
    #1;
    checks++; if (imem_addr !== 32'h3FC) begin errors++; $display("FAIL fetch_pass_3fc: got %h want 3fc", imem_addr); end
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    model_reset();
    checks++; if (cpu_stall !== 1'b1 || pc_rst !== 1'b1) begin errors++; $display("FAIL reload_stall: stall=%b pc_rst=%b want 1 1", cpu_stall, pc_rst); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b want 1", ld_ready); end
    checks++; if (word_cnt !== 32'h0) begin errors++; $display("FAIL reload_word_cnt: got %0d want 0", word_cnt); end
    checks++; if (ld_err8 !== 1'b0) begin errors++; $display("FAIL reload_clears_err: got %b want 0", ld_err8); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reload_addr: got %h want 0", imem_addr); end
    send_word(32'hCAFEF00D, 1'b1, 0);
    wait_run();
    checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL reload_count: got %0d want 1", word_cnt); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL reload_pending: got %0d bytes left want 0", q.size()); end
  endtask

  task automatic test_boot_req_ignored();
    int n;
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    model_reset();
    send_word(32'h01020304, 1'b0, 0);
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    checks++; if (mem_we !== 1'b1 || imem_addr !== 32'h1) begin errors++; $display("FAIL breq_write: we=%b addr=%h want 1 1", mem_we, imem_addr); end
    n = 0;
    while (ld_ready !== 1'b1 && n < 10) begin step(); n++; end
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    checks++; if (ld_ready !== 1'b1 || word_cnt !== 32'd1) begin errors++; $display("FAIL breq_wait: ready=%b cnt=%0d want 1 1", ld_ready, word_cnt); end
    send_word(32'h05060708, 1'b1, 0);
    wait_run();
    checks++; if (word_cnt !== 32'd2) begin errors++; $display("FAIL breq_count: got %0d want 2", word_cnt); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL breq_pending: got %0d bytes left want 0", q.size()); end
  endtask

  task automatic test_reset_mid_write();
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    model_reset();
    send_word(32'h0A0B0C0D, 1'b0, 0);
    send_word(32'h10203040, 1'b1, 0);
    step();
    step();
    checks++; if (mem_we !== 1'b1 || imem_addr !== 32'h6) begin errors++; $display("FAIL midrst_pre: we=%b addr=%h want 1 6", mem_we, imem_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL midrst_state: ready=%b stall=%b want 1 1", ld_ready, cpu_stall); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b want 0", mem_we); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_base: got %h want 0", imem_addr); end
    checks++; if (word_cnt !== 32'h0) begin errors++; $display("FAIL midrst_word_cnt: got %0d want 0", word_cnt); end
    checks++; if (q.size() != 1) begin errors++; $display("FAIL midrst_bytes: got %0d bytes unwritten want 1", q.size()); end
    model_reset();
    send_word(32'h99887766, 1'b1, 0);
    wait_run();
    checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL midrst_recover: got %0d want 1", word_cnt); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL midrst_pending: got %0d bytes left want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gaps_and_overflow();
    test_run_fetch();
    test_boot_req_ignored();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
